fp_operand_loader: RTL
======================

FP_OPERAND_LOADER -- requirements
Module: fp_operand_loader

Interface
REQ-001 Parameter N, default 32, operand width in bits; fixed at 32 for IEEE-754 single precision.
REQ-002 Parameter NIBBLES, default 8, number of 4-bit digits per operand (N/4).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 nibble  input  4  digit value from debounced switches; sampled on an enter event.
REQ-006 enter  input  1  debounced push-button level; each rising edge is one enter event.
REQ-007 clear  input  1  debounced level; while high, discards any entry in progress.
REQ-008 out_ready  input  1  adder side accepts the operand pair.
REQ-009 op_a  output  32  operand A to the adder.
REQ-010 op_b  output  32  operand B to the adder.
REQ-011 out_valid  output  1  op_a/op_b hold a complete pair.
REQ-012 exc  output  1  either operand has exponent 8'hFF (Inf/NaN) or is denormal with a nonzero mantissa.
REQ-013 state_led  output  3  one-hot LED code: [0] LOAD_A, [1] LOAD_B, [2] VALID.
REQ-014 digit_idx  output  3  index of the next digit expected, 0 = most significant.

Function
REQ-015 The state machine SHALL have exactly three states: LOAD_A, LOAD_B and VALID.
REQ-016 An enter event SHALL be detected one cycle after enter goes from 0 to 1, with the previous enter level held in a flop.
- Holding enter high SHALL produce exactly one event.
REQ-017 In LOAD_A, each enter event SHALL shift nibble into the A register from the LSB side.
- The shift is {a[27:0], nibble], so the first digit entered ends up in bits [31:28].
REQ-018 digit_idx SHALL increment on each accepted digit and wrap from 7 to 0.
REQ-019 The 8th accepted digit in LOAD_A SHALL move the machine to LOAD_B on the same edge that captures the digit.
REQ-020 LOAD_B SHALL shift digits into the B register by the same rule; its 8th digit SHALL move the machine to VALID.
REQ-021 out_valid SHALL be registered and SHALL equal 1 exactly while the state is VALID.
- Latency from the 16th enter event to out_valid=1 is one cycle.
REQ-022 While out_valid=1, op_a, op_b and exc SHALL stay stable, and enter events SHALL be ignored.
REQ-023 Transfer SHALL occur on a clock edge where out_valid=1 and out_ready=1.
- On that edge the state SHALL go to LOAD_A and digit_idx to 0.
- op_a and op_b SHALL keep their values until the first new digit shifts into them.
REQ-024 out_ready while not in VALID SHALL have no effect.
REQ-025 clear=1 SHALL, on the next edge and from any state, force LOAD_A, digit_idx=0, A=0, B=0 and out_valid=0.
REQ-026 clear SHALL take priority over a simultaneous enter event and over a simultaneous transfer.
REQ-027 exc SHALL be computed combinationally from the A and B registers and gated by out_valid.

Reset
REQ-028 While reset=0, the block SHALL hold: state LOAD_A, op_a=0, op_b=0, out_valid=0, digit_idx=0, edge flop=0, state_led=3'b001.
- This applies independently of clk.
REQ-029 Reset asserted mid-entry SHALL discard all partial digits, with no pending event remaining after release.
REQ-030 The first rising edge of enter after reset is released SHALL count as an event only if enter was sampled low for at least one cycle.

Structure
REQ-031 Package fp_pkg SHALL hold:
- the float32 packed struct {sign[1], exp[8], man[23]};
- the EXP_MAX constant (8'hFF);
- the NIBBLES constant;
- the loader state enum.
REQ-032 The edge detector SHALL be a separate sub-module named rise_detect (inputs clk, reset, level; output pulse).
REQ-033 The top SHALL contain one FSM and two 32-bit shift registers.

Verification
REQ-034 Enter digits 0,3,0,0,2,0,0,0 then 0,0,8,0,0,0,4,0 -> out_valid=1 one cycle after the 16th event, op_a=32'h03002000, op_b=32'h00800040, exc=0.
REQ-035 In VALID, hold out_ready=0 for 10 cycles with 3 enter events -> operands unchanged; then out_ready=1 for one cycle -> state_led=3'b001, out_valid=0.
REQ-036 Enter 5 digits of A, then assert clear simultaneously with an enter event -> digit_idx=0, op_a=0, LOAD_A.
REQ-037 Load A=32'h7F800000, B=32'h3F800000 -> exc=1 when out_valid=1.
REQ-038 Drop reset asynchronously while in LOAD_B (digit_idx=4) -> all outputs are at reset values before the next clk edge.
REQ-039 Hold enter high for 50 cycles -> exactly one digit is accepted.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared float32 view, entry constants and loader state encoding for the operand loader.
package fp_pkg;

    localparam int         NIBBLES = 8;
    localparam logic [7:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } float32_t;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        VALID  = 2'd2
    } loader_state_e;

    // Inf/NaN, or a denormal that is not a plain zero.
    function automatic logic is_special(input float32_t f);
        return (f.exp == EXP_MAX) || ((f.exp == 8'h00) && (f.man != 23'h0));
    endfunction

endpackage

// File: rtl/fp_operand_loader_if.sv
// Digit-entry inputs and operand-pair handshake between the switch front end and the FP adder.
interface fp_operand_loader_if;

    logic [3:0]  nibble;
    logic        enter;
    logic        clear;
    logic        out_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        exc;
    logic [2:0]  state_led;
    logic [2:0]  digit_idx;

    modport master (
        output nibble, enter, clear, out_ready,
        input  op_a, op_b, out_valid, exc, state_led, digit_idx
    );

    modport slave (
        input  nibble, enter, clear, out_ready,
        output op_a, op_b, out_valid, exc, state_led, digit_idx
    );

endinterface

// File: rtl/rise_detect.sv
// Registered 0->1 detector: one pulse, one cycle after the level is first sampled high.
// No backpressure; only armed once the level has been sampled low after reset.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic prev_q;
    logic armed_q, armed_d;
    logic pulse_q, pulse_d;

    assign armed_d = armed_q | ~level;
    assign pulse_d = level & ~prev_q & armed_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= level;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/fp_operand_loader.sv
// Collects two float32 operands as 8 hex digits each; out_valid one cycle after the 16th digit.
// Pair held stable with entry ignored until out_ready; clear aborts entry from any state.
module fp_operand_loader #(
    parameter int N       = 32,
    parameter int NIBBLES = 8
) (
    input logic               clk,
    input logic               reset,
    fp_operand_loader_if.slave bus
);

    import fp_pkg::*;

    logic          enter_evt;
    loader_state_e state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [2:0]    idx_q, idx_d;
    logic          out_valid_q, out_valid_d;
    logic          shift_a, shift_b;
    logic          last_digit;
    logic          transfer;
    logic [2:0]    led;

    rise_detect u_enter_rise (
        .clk   (clk),
        .reset (reset),
        .level (bus.enter),
        .pulse (enter_evt)
    );

    assign last_digit = (idx_q == 3'(NIBBLES - 1));
    assign transfer   = out_valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOAD_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = LOAD_A;
        end else begin
            case (state_q)
                LOAD_A:  if (enter_evt && last_digit) state_d = LOAD_B;
                LOAD_B:  if (enter_evt && last_digit) state_d = VALID;
                VALID:   if (transfer)                state_d = LOAD_A;
                default:                              state_d = LOAD_A;
            endcase
        end
    end

    // Enter events in VALID fall through here without enabling either shift.
    always_comb begin
        shift_a = 1'b0;
        shift_b = 1'b0;
        led     = 3'b001;
        case (state_q)
            LOAD_A: begin
                shift_a = enter_evt & ~bus.clear;
                led     = 3'b001;
            end
            LOAD_B: begin
                shift_b = enter_evt & ~bus.clear;
                led     = 3'b010;
            end
            VALID: begin
                led     = 3'b100;
            end
            default: begin
                led     = 3'b001;
            end
        endcase
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        idx_d = idx_q;
        if (bus.clear) begin
            a_d   = '0;
            b_d   = '0;
            idx_d = '0;
        end else if (shift_a) begin
            a_d   = {a_q[N-5:0], bus.nibble};
            idx_d = idx_q + 3'd1;
        end else if (shift_b) begin
            b_d   = {b_q[N-5:0], bus.nibble};
            idx_d = idx_q + 3'd1;
        end else if (transfer) begin
            idx_d = '0;
        end
    end

    assign out_valid_d = (state_d == VALID);

    // Operands are left in place after a transfer; the next digit overwrites them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q         <= '0;
            b_q         <= '0;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a_q         <= a_d;
            b_q         <= b_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.op_a      = a_q;
    assign bus.op_b      = b_q;
    assign bus.out_valid = out_valid_q;
    assign bus.digit_idx = idx_q;
    assign bus.state_led = led;
    assign bus.exc       = out_valid_q &
                           (is_special(float32_t'(a_q)) | is_special(float32_t'(b_q)));

endmodule
